// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding, frame header and checksum width for the core loader
package loader_pkg;

  localparam logic [7:0] LOADER_HDR    = 8'hA5;
  localparam int         LOADER_CSUM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LEN0      = 3'd1,
    ST_LEN1      = 3'd2,
    ST_DATA      = 3'd3,
    ST_CSUM      = 3'd4,
    ST_START     = 3'd5,
    ST_WAIT_LOW  = 3'd6,
    ST_WAIT_HIGH = 3'd7
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - LSB-first byte-to-word assembly with a word-complete pulse
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_complete
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_clr) begin
      r_idx   <= '0;
    end else if (i_valid) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  // Only the three earlier bytes are stored; the fourth is taken straight from the input
  assign o_word     = {i_byte, r_shift};
  assign o_complete = i_valid && (r_idx == 2'd3);

endmodule

// File: rtl/core_loader.sv
// rtl/core_loader.sv - framed byte loader into core memory, then run and time the core (CORE_LOADER_CHECKSUM_EN adds checksum byte)
module core_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        run,
  input  logic        done,
  output logic        busy,
  output logic        err,
  output logic [31:0] run_cycles
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  loader_state_t r_state;
  logic          r_live;
  logic [7:0]    r_len_lo;
  logic [15:0]   r_left;
  logic [31:0]   r_next_addr;
  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic          r_err;
  logic [31:0]   r_cycles;
`ifdef CORE_LOADER_CHECKSUM_EN
  logic [LOADER_CSUM_W-1:0] r_csum;
`endif

  logic        w_rx_state;
  logic        w_accept;
  logic        w_hdr;
  logic        w_word_done;
  logic [31:0] w_word;
  logic [15:0] w_len;

  always_comb begin
    w_rx_state = 1'b0;
    case (r_state)
      ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA: w_rx_state = 1'b1;
`ifdef CORE_LOADER_CHECKSUM_EN
      ST_CSUM:                            w_rx_state = 1'b1;
`endif
      default:                            w_rx_state = 1'b0;
    endcase
  end

  // r_live holds byte_ready low until the first edge after reset release
  assign byte_ready = r_live && w_rx_state;
  assign w_accept   = byte_valid && byte_ready;
  assign w_hdr      = w_accept && (r_state == ST_IDLE) && (byte_data == LOADER_HDR);
  assign w_len      = {byte_data, r_len_lo};

  assign busy       = (r_state != ST_IDLE);
  assign run        = (r_state == ST_START);
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign err        = r_err;
  assign run_cycles = r_cycles;

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_hdr),
    .i_valid    (w_accept && (r_state == ST_DATA)),
    .i_byte     (byte_data),
    .o_word     (w_word),
    .o_complete (w_word_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_live      <= 1'b0;
      r_len_lo    <= '0;
      r_left      <= '0;
      r_next_addr <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
      r_cycles    <= '0;
`ifdef CORE_LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_live   <= 1'b1;
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hdr) begin
            r_err       <= 1'b0;
            r_next_addr <= BASE_ADDR;
`ifdef CORE_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
            r_state     <= ST_LEN0;
          end else if (w_accept) begin
            r_err <= 1'b1;
          end
        end
        ST_LEN0: begin
          if (w_accept) begin
            r_len_lo <= byte_data;
            r_state  <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (w_accept) begin
            if (w_len == 16'd0) begin
              r_state <= ST_CSUM;
            end else if ({1'b0, w_len} > MAX_W) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_left  <= w_len;
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
`ifdef CORE_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ byte_data;
`endif
            if (w_word_done) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_next_addr;
              r_mem_wdata <= w_word;
              r_next_addr <= r_next_addr + 32'd4;
              r_left      <= r_left - 16'd1;
              if (r_left == 16'd1) r_state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
`ifdef CORE_LOADER_CHECKSUM_EN
          if (w_accept) begin
            if (byte_data == r_csum) begin
              r_state <= ST_START;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
`else
          r_state <= ST_START;
`endif
        end
        ST_START: begin
          r_cycles <= '0;
          r_state  <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
          if (!done) r_state <= ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          if (r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
          if (done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_loader.sv
// tb/tb_core_loader.sv - directed scoreboard bench for core_loader
module tb_core_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        run;
  logic        done;
  logic        busy;
  logic        err;
  logic [31:0] run_cycles;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          run_cnt  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [7:0]  csum_m;

  always #5 clk = ~clk;

  core_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .run        (run),
    .done       (done),
    .busy       (busy),
    .err        (err),
    .run_cycles (run_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (run === 1'b1) run_cnt++;
    if (mem_we === 1'b1) begin
      check("we_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("we_addr", mem_addr, mon_e[63:32]);
        check("we_data", mem_wdata, mon_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(8'hA5);
    csum_m = 8'h00;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input int k, input logic [31:0] w);
    exp_q.push_back({BASE + 32'(k * 4), w});
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      csum_m = csum_m ^ w[8*i +: 8];
    end
  endtask

  task automatic send_csum(input logic [7:0] x);
`ifdef CORE_LOADER_CHECKSUM_EN
    send_byte(x);
`else
    if (x === 8'hxx) csum_m = 8'h00;
`endif
  endtask

  task automatic run_core(input int low);
    int t;
    t = 0;
    while (run !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("run_seen", {31'd0, run}, 32'd1);
    @(posedge clk); #1;
    done = 1'b0;
    check("ready_low_run", {31'd0, byte_ready}, 32'd0);
    check("busy_run", {31'd0, busy}, 32'd1);
    repeat (low) @(posedge clk);
    #1;
    done = 1'b1;
    t = 0;
    while (busy !== 1'b0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("run_cycles", run_cycles, 32'(low + 1));
  endtask

  initial begin
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    done       = 1'b1;
    csum_m     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_run", {31'd0, run}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cycles", run_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, byte_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {31'd0, byte_ready}, 32'd1);

    // two-word frame from the reference example
    send_header(16'd2);
    send_word(0, 32'h0000_0013);
    send_word(1, 32'h0010_0093);
    send_csum(8'h90);
    run_core(3);
    check("run_cnt_1", run_cnt, 32'd1);
    check("err_ok_1", {31'd0, err}, 32'd0);

`ifdef CORE_LOADER_CHECKSUM_EN
    send_header(16'd2);
    send_word(0, 32'h0000_0013);
    send_word(1, 32'h0010_0093);
    send_csum(8'h91);
    repeat (3) @(posedge clk);
    #1;
    check("csum_err", {31'd0, err}, 32'd1);
    check("csum_idle", {31'd0, busy}, 32'd0);
    check("csum_no_run", run_cnt, 32'd1);
`endif

    send_byte(8'h3C);
    check("bad_hdr_err", {31'd0, err}, 32'd1);
    check("bad_hdr_ready", {31'd0, byte_ready}, 32'd1);
    check("bad_hdr_idle", {31'd0, busy}, 32'd0);

    // empty frame: no writes, run and time the core
    send_header(16'd0);
    check("hdr_clears_err", {31'd0, err}, 32'd0);
    send_csum(8'h00);
    run_core(10);
    check("run_cnt_2", run_cnt, 32'd2);

    send_header(16'd3);
    send_word(0, 32'hDEAD_BEEF);
    send_word(1, 32'h0123_4567);
    send_word(2, 32'h89AB_CDEF);
    send_csum(csum_m);
    run_core(1);
    check("run_cnt_3", run_cnt, 32'd3);
    check("err_ok_3", {31'd0, err}, 32'd0);

    send_header(16'h0401);
    repeat (2) @(posedge clk);
    #1;
    check("too_long_err", {31'd0, err}, 32'd1);
    check("too_long_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of word 1
    send_header(16'd2);
    send_word(0, 32'hCAFE_F00D);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    reset = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    send_byte(8'h44);
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_err", {31'd0, err}, 32'd1);
    check("run_cnt_final", run_cnt, 32'd3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
